// File: rtl/q3_muldiv.sv
// q3_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 multiplier for MUL*.
module q3_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_count;
    logic [2:0]  r_f3;
    logic        r_neg;
    logic [31:0] r_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_result;

    logic        w_valid;
    logic [2:0]  w_f3;
    logic        w_is_div;
    logic        w_sgn1;
    logic        w_sgn2;
    logic        w_s1;
    logic        w_s2;
    logic        w_neg;
    logic [31:0] w_m1;
    logic [31:0] w_m2;
    logic        w_dz;
    logic        w_ovf;
    logic        w_fast;
    logic [31:0] w_fast_res;
    logic [32:0] w_sum;
    logic [32:0] w_sh;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [31:0] w_hi_n;
    logic [31:0] w_lo_n;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_final;
    logic        w_unused;

    assign w_valid = start_i
                   && (instr_i[6:0] == 7'b0110011)
                   && (instr_i[31:25] == 7'b0000001);
    assign w_f3     = instr_i[14:12];
    assign w_is_div = w_f3[2];

    // Which operands are treated as signed: MULH, MULHSU(rs1), DIV, REM.
    assign w_sgn1 = (w_f3 == 3'b001) || (w_f3 == 3'b010)
                 || (w_f3 == 3'b100) || (w_f3 == 3'b110);
    assign w_sgn2 = (w_f3 == 3'b001) || (w_f3 == 3'b100)
                 || (w_f3 == 3'b110);
    assign w_s1 = w_sgn1 & rs1_i[31];
    assign w_s2 = w_sgn2 & rs2_i[31];
    assign w_m1 = w_s1 ? (32'd0 - rs1_i) : rs1_i;
    assign w_m2 = w_s2 ? (32'd0 - rs2_i) : rs2_i;

    // Remainder follows the dividend; products and quotients the xor.
    assign w_neg = (w_f3 == 3'b110) ? w_s1 : (w_s1 ^ w_s2);

    assign w_dz  = w_is_div && (rs2_i == 32'd0);
    assign w_ovf = w_is_div && !w_f3[0]
                && (rs1_i == 32'h8000_0000)
                && (rs2_i == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [65:0] w_fmul;
    logic               w_unused_mul;
    assign w_fmul = $signed({w_s1, rs1_i}) * $signed({w_s2, rs2_i});
    assign w_unused_mul = ^w_fmul[65:64];
    assign w_fast = w_dz || w_ovf || !w_is_div;
    assign w_fast_res = w_dz  ? (w_f3[1] ? rs1_i : 32'hFFFF_FFFF) :
                        w_ovf ? (w_f3[1] ? 32'd0 : 32'h8000_0000) :
                        (w_f3 == 3'b000) ? w_fmul[31:0] :
                        w_fmul[63:32];
`else
    assign w_fast = w_dz || w_ovf;
    assign w_fast_res = w_dz  ? (w_f3[1] ? rs1_i : 32'hFFFF_FFFF) :
                        w_ovf ? (w_f3[1] ? 32'd0 : 32'h8000_0000) :
                        32'd0;
`endif

    // Shift-add step: add multiplicand into the high half, shift right.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);

    // Restoring step: shift remainder left, subtract divisor if it fits.
    assign w_sh   = {r_hi, r_lo[31]};
    assign w_diff = {1'b0, w_sh} - {2'b00, r_a};
    assign w_ge   = !w_diff[33];

    assign w_hi_n = r_f3[2] ? (w_ge ? w_diff[31:0] : w_sh[31:0])
                            : w_sum[32:1];
    assign w_lo_n = r_f3[2] ? {r_lo[30:0], w_ge}
                            : {w_sum[0], r_lo[31:1]};

    assign w_prod     = {w_hi_n, w_lo_n};
    assign w_prod_fix = r_neg ? (64'd0 - w_prod) : w_prod;
    assign w_quo      = r_neg ? (32'd0 - w_lo_n) : w_lo_n;
    assign w_rem      = r_neg ? (32'd0 - w_hi_n) : w_hi_n;

    assign w_final = r_f3[2] ? (r_f3[1] ? w_rem : w_quo) :
                     (r_f3 == 3'b000) ? w_prod_fix[31:0] :
                     w_prod_fix[63:32];

    assign w_unused = ^{instr_i[24:15], instr_i[11:7], w_diff[32]};

    assign stall_o  = !rst && (((r_state == S_IDLE) && w_valid && !flush_i)
                   || (r_state == S_CALC));
    assign done_o   = (r_state == S_DONE);
    assign result_o = done_o ? r_result : 32'd0;

    // Control FSM plus the shared shift datapath and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= 6'd0;
            r_f3     <= 3'd0;
            r_neg    <= 1'b0;
            r_a      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid && !flush_i) begin
                        r_f3    <= w_f3;
                        r_neg   <= w_neg;
                        r_count <= 6'd0;
                        r_a     <= w_is_div ? w_m2 : w_m1;
                        r_hi    <= 32'd0;
                        r_lo    <= w_is_div ? w_m1 : w_m2;
                        if (w_fast) begin
                            r_state  <= S_DONE;
                            r_result <= w_fast_res;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi    <= w_hi_n;
                        r_lo    <= w_lo_n;
                        r_count <= r_count + 6'd1;
                        if (r_count == 6'd31) begin
                            r_state  <= S_DONE;
                            r_result <= w_final;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q3_muldiv.sv
// tb_q3_muldiv: random and directed RV32M checks against a
// plain-arithmetic reference model, latency and flush/reset behaviour.
module tb_q3_muldiv;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int total;
    int bad;

    q3_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .instr_i  (instr_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        bit ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        if (f3 == 3'd0 || f3 == 3'd3) x = {32'd0, a};
        if (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd3) y = {32'd0, b};
        p = x * y;
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sq = sa / sb;
                return sq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sq = sa % sb;
                return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        logic [31:0] er;
        int el;
        int n;
        bit seen;
        bit st_ok;
        bit rz_ok;
        er = model(f3, a, b);
        el = exp_lat(f3, a, b);
        start_i = 1'b1;
        instr_i = mk(f3);
        rs1_i   = a;
        rs2_i   = b;
        flush_i = 1'b0;
        #1;
        chk({tag, "_stall_acc"}, stall_o, 1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n = 1;
        seen = 0;
        st_ok = 1;
        rz_ok = 1;
        while (!seen && n <= 40) begin
            if (noise) begin
                start_i = 1'($urandom % 2);
                instr_i = mk(3'($urandom % 8));
                rs1_i   = $urandom;
                rs2_i   = $urandom;
            end
            #1;
            if (done_o) begin
                seen = 1;
            end else begin
                if (stall_o !== 1'b1) st_ok = 0;
                if (result_o !== 32'd0) rz_ok = 0;
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk({tag, "_lat"}, 64'(n), 64'(el));
        chk({tag, "_res"}, result_o, er);
        chk({tag, "_stall_done"}, stall_o, 0);
        if (el > 1) begin
            chk({tag, "_stall_calc"}, st_ok, 1);
            chk({tag, "_res_zero"}, rz_ok, 1);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, done_o, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit any;
        any = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_o) any = 1;
        end
        @(posedge clk);
        #1;
        chk(tag, any, 0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start_i = 1'b1;
        instr_i = mk(3'd0);
        rs1_i   = 32'd3;
        rs2_i   = 32'd4;
        flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_res", result_o, 0);
        start_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_done", done_o, 0);

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_ff", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 0);
        run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd1, 0);

        start_i = 1'b1;
        instr_i = mk(3'd0) ^ 32'h0000_0001;
        #1;
        chk("bad_op_stall", stall_o, 0);
        @(posedge clk);
        #1;
        instr_i = mk(3'd0) | 32'h8000_0000;
        #1;
        chk("bad_f7_stall", stall_o, 0);
        @(posedge clk);
        #1;
        instr_i = mk(3'd5);
        flush_i = 1'b1;
        #1;
        chk("idle_flush_stall", stall_o, 0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        quiet("ignored_no_done", 36);

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom % 8);
            a  = $urandom;
            b  = $urandom;
            case ($urandom % 6)
                0: b = 32'd0;
                1: b = $urandom % 16;
                2: a = $urandom % 64;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", k), f3, a, b, 1'($urandom % 2));
        end

        start_i = 1'b1;
        instr_i = mk(3'd5);
        rs1_i   = 32'd1000;
        rs2_i   = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_done", done_o, 0);
        chk("flush_stall", stall_o, 0);
        quiet("flush_no_done", 36);

        start_i = 1'b1;
        instr_i = mk(3'd0);
        rs1_i   = 32'd11;
        rs2_i   = 32'd13;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_done", done_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_res", result_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        quiet("arst_no_done", 36);
        run_op("after_rst", 3'd4, 32'hFFFF_FF9C, 32'd7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/q3_muldiv.md
Q3_MULDIV -- requirements
Module: q3_muldiv

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32-bit RV32M.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start_i  in  1  execute stage presents an M-extension instruction in this cycle.
REQ-005 instr_i  in  32  instruction from the decode/execute register; funct3 = [14:12] selects the op.
REQ-006 rs1_i  in  32  operand 1 from the decode/execute register.
REQ-007 rs2_i  in  32  operand 2 from the decode/execute register.
REQ-008 flush_i  in  1  branch/exception kill of the instruction in execute.
REQ-009 stall_o  out  1  holds upstream pipeline registers while the unit works.
REQ-010 done_o  out  1  one-cycle pulse; result_o valid in this cycle.
REQ-011 result_o  out  32  rd write data.

Function
REQ-012 Valid request: start_i=1 and instr_i[6:0]=0110011 and instr_i[31:25]=0000001; any other start_i is ignored.
REQ-013 States: IDLE, CALC, DONE.
REQ-014 IDLE + valid request + flush_i=0: the unit latches operands and funct3, clears count to 0, and enters CALC.
REQ-015 The CALC path from REQ-014 is overridden by REQ-020 and REQ-021.
REQ-016 CALC: one radix-2 step per cycle, shift-add for MUL*, restoring for DIV*/REM*.
REQ-017 CALC: after step 31, count reaches 32 and the next state is DONE.
REQ-018 Operands: signed ops (MULH, MULHSU rs1 only, DIV, REM) use magnitudes.
REQ-019 Sign fix-up on the final result: product negated if the operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-020 Divide by zero skips CALC and goes IDLE->DONE; quotient = 0xFFFFFFFF, remainder = rs1.
REQ-021 DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF skips CALC; quotient = 0x80000000, remainder = 0.
REQ-022 Results: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32].
REQ-023 Latency, iterative path: done_o is high in the 33rd cycle after the accepting edge.
REQ-024 Latency, fast paths: done_o is high in the cycle after the accepting edge.
REQ-025 DONE: done_o=1, result_o valid; the state returns to IDLE on the next edge.
REQ-026 done_o is low in every state other than DONE.
REQ-027 result_o is 0 whenever done_o=0.
REQ-028 stall_o = (IDLE and valid request and not flush_i) or CALC; this is combinational and low in DONE, so the pipeline advances while the result is captured.
REQ-029 flush_i in CALC or DONE: the next state is IDLE; no done_o pulse follows; a DONE-cycle result is still driven but discarded downstream.
REQ-030 A request while in CALC or DONE is not accepted; back-to-back issue needs one IDLE cycle.
REQ-031 Count is 6 bits and does not wrap; it is cleared on acceptance.

Reset
REQ-032 rst asserted forces IDLE immediately, regardless of clk.
REQ-033 During and after reset, until a request is accepted: count=0, operand/accumulator registers=0, done_o=0, stall_o=0, result_o=0.
REQ-034 Reset mid-CALC abandons the operation with no done_o pulse.

Configuration
REQ-035 The unit SHALL honour macro MULDIV_FAST_MUL_EN.
REQ-036 Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier and go IDLE->DONE with 1-cycle latency.
REQ-037 Defined: divides are unchanged.
REQ-038 Undefined: all ops use the iterative CALC path per REQ-023, with no hardware multiplier inferred.

Verification
REQ-039 MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; done_o at cycle 33 (cycle 1 with macro); stall_o high until then.
REQ-040 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-041 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
REQ-042 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, both with done_o one cycle after acceptance.
REQ-043 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with 1-cycle latency.
REQ-044 Assert flush_i at count=10, then rst at count=5 of a new op -> no done_o, IDLE next, stall_o=0; a new request is then accepted normally.
